// File: rtl/sim_net_packet_buffer.sv
// sim_net_packet_buffer: receive-side store-and-forward flit buffer.
// Inbound flits are written behind a tentative pointer and only become
// visible to the NIC side once the packet's last flit has arrived.
// A packet that cannot fit (flit storage or packet slots) is dropped whole.
//
// Handshake: a flit moves on a side in any cycle where valid && ready are both
// high at the rising clock edge. The inbound side is always ready out of reset
// and is never back-pressured. The outbound side holds out_valid/out_data/
// out_last stable until the flit is taken, and never withdraws out_valid in
// the middle of a packet because the whole packet is already resident.
module sim_net_packet_buffer #(
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_data,
    output logic                      out_last,
    output logic [31:0]               drop_count,
    output logic [$clog2(MAX_PKTS):0] pkt_count,
    output logic [1:0]                fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKTS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_commit;
    logic [PW-1:0]     wr_tmp;
    logic [PW-1:0]     used;

    logic [64:0]       mem [DEPTH];

    logic              accept;
    logic              space_full;
    logic              slots_full;
    logic              out_fire;
    logic              pop_last;
    logic              wr_en;
    logic              do_commit;
    logic              do_drop;

    assign in_ready   = reset;
    assign accept     = in_valid && in_ready;

    // Occupancy counts committed and in-progress flits; registered pointers only.
    assign used       = wr_tmp - rd_ptr;
    assign space_full = (used == PW'(DEPTH));
    assign slots_full = (pkt_count == CW'(MAX_PKTS));

    assign out_valid  = (pkt_count != '0);
    assign out_data   = mem[rd_ptr[AW-1:0]][63:0];
    assign out_last   = mem[rd_ptr[AW-1:0]][64];
    assign out_fire   = out_valid && out_ready;
    assign pop_last   = out_fire && out_last;

    assign fsm_state  = state;

    // Decode what the accepted inbound flit does: write, commit, start or finish a drop.
    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        do_commit  = 1'b0;
        do_drop    = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (slots_full || space_full) begin
                        // A one-flit packet that does not fit is dropped on the spot.
                        if (in_last) begin
                            do_drop = 1'b1;
                        end else begin
                            next_state = S_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (in_last) begin
                            do_commit = 1'b1;
                        end else begin
                            next_state = S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (space_full) begin
                        if (in_last) begin
                            do_drop    = 1'b1;
                            next_state = S_IDLE;
                        end else begin
                            next_state = S_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (in_last) begin
                            do_commit  = 1'b1;
                            next_state = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (in_last) begin
                        do_drop    = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    // Flit storage; contents need no reset since out_valid gates their use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_tmp[AW-1:0]] <= {in_last, in_data};
        end
    end

    // Inbound state machine, pointers, packet count and drop counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_commit  <= '0;
            wr_tmp     <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            state <= next_state;

            if (wr_en) begin
                wr_tmp <= wr_tmp + PW'(1);
            end

            if (do_commit) begin
                wr_commit <= wr_tmp + PW'(1);
            end

            // A finished drop discards everything written since the last commit.
            if (do_drop) begin
                wr_tmp <= wr_commit;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 32'd1;
                end
            end

            if (out_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            // Commit and last-flit departure in the same cycle cancel out.
            case ({do_commit, pop_last})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: doc/sim_net_packet_buffer.md
# sim_net_packet_buffer

Receive-side packet buffer between the simulated network endpoint's inbound flit stream (64-bit data + last) and the NIC receive path. It stores incoming flits and releases a packet downstream only after its last flit has arrived. Packets that do not fit are dropped whole. The inbound side never stalls, because the simulated link cannot be back-pressured meaningfully.

## Interface
Parameters:
- DEPTH, 64, flit storage entries; power of two, ≥ 4
- MAX_PKTS, 8, maximum committed (complete) packets held at once

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = in reset)
- in_valid  in  1  inbound flit valid
- in_ready  out  1  inbound ready
- in_data  in  64  inbound flit payload
- in_last  in  1  final flit of inbound packet
- out_valid  out  1  outbound flit valid
- out_ready  in  1  outbound ready from NIC
- out_data  out  64  outbound flit payload
- out_last  out  1  final flit of outbound packet
- drop_count  out  32  packets dropped since reset; saturates at 0xFFFFFFFF
- pkt_count  out  log2(MAX_PKTS)+1  committed packets currently buffered

## Operation
- Storage: DEPTH × 65 bits (data, last). Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
- Pointers: rd_ptr (head), wr_commit (end of last committed packet), wr_tmp (write position of the packet in progress).
- Inbound state machine, states IDLE / RECV / DROP:
  - IDLE, flit accepted: if pkt_count == MAX_PKTS or wr_tmp − rd_ptr == DEPTH, go to DROP. Otherwise write the flit and go to RECV. A single-flit packet commits immediately and stays in IDLE.
  - RECV, flit accepted: if wr_tmp − rd_ptr == DEPTH, the flit is not written and the state goes to DROP. Otherwise write the flit; if in_last, commit and go to IDLE.
  - DROP, flit accepted: discard it. If in_last, go to IDLE, increment drop_count, and rewind wr_tmp to wr_commit.
  - Any drop caused by a DROP transition that occurs on the packet's last flit completes the drop in the same cycle: go to IDLE, rewind, and count it.
- Commit: wr_commit ← wr_tmp+1 (including the last flit), and pkt_count increments.
- in_ready = 1 whenever reset is high. Any packet longer than DEPTH is always dropped.
- Outbound: out_valid = (pkt_count != 0). out_data and out_last come combinationally from mem[rd_ptr].
  - On out_valid && out_ready, rd_ptr increments.
  - If that flit has last set, pkt_count decrements.
- Commit and outbound last-flit handshake in the same cycle: pkt_count is unchanged.
- Freed space is visible to the full check on the cycle after the read.

## Timing
- Reset values: in_ready 0 (during reset), out_valid 0, out_data/out_last don't-care while out_valid = 0, drop_count 0, pkt_count 0. All pointers are 0 and the state is IDLE.
- Reset asserted mid-packet: the partial and all buffered packets are discarded with no drop_count increment. The first flit seen after reset is treated as a packet start.
- Latency: the last inbound flit accepted at edge N makes out_valid = 1 from edge N+1 (when the buffer was empty). There is no bypass.
- Throughput: one flit per cycle on each side, simultaneously.
- out_valid, out_data and out_last hold stable until accepted. out_valid never deasserts mid-packet because the whole packet is resident.
- The full check uses registered pointers only. A read and a write in the same cycle never conflict, because committed and in-progress regions are disjoint.

## Test plan
- Single 3-flit packet (0xA1, 0xA2, 0xA3 with last), out_ready = 1: out_valid rises the cycle after 0xA3 and delivers the three flits in order with out_last on 0xA3. pkt_count goes 0→1→0.
- Same packet with out_ready = 0 for 10 cycles: out_valid stays 1 and out_data holds 0xA1. Flits drain on release and no drop occurs.
- DEPTH=8, out_ready = 0, one 10-flit packet followed by a 4-flit packet: the first is dropped (drop_count = 1) and the second is delivered intact.
- MAX_PKTS=2, out_ready = 0, three 1-flit packets: the third is dropped (drop_count = 1, pkt_count = 2). Releasing out_ready then delivers exactly two packets.
- Commit and outbound last-flit handshake in the same cycle with pkt_count = 1: pkt_count stays 1 and the new packet follows without a gap.
- Reset low for 1 cycle during the 2nd flit of a 5-flit packet: all outputs return to reset values and drop_count = 0. A subsequent 2-flit packet is delivered correctly.
